// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO read port and serialises them as UART 8N1.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DV_TIMEOUT   = 15
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       fifo_empty_i,
   output logic       fifo_rd_en_o,
   input  logic       fifo_rd_dv_i,
   input  logic [7:0] fifo_rd_data_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       timeout_o
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int WW = $clog2(DV_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(DV_TIMEOUT - 1);
   typedef enum logic [2:0] {IDLE, REQ, WAIT_DV, START, DATA, STOP} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic [WW-1:0] wait_q, wait_d;
   logic tx_q, tx_d, timeout_q, timeout_d;
   logic bit_end, serial;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         wait_q    <= '0;
         tx_q      <= 1'b1;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         wait_q    <= wait_d;
         tx_q      <= tx_d;
         timeout_q <= timeout_d;
      end
   end
   always_comb begin
      bit_end   = cnt_q == CNT_LAST;
      serial    = state_q inside {START, DATA, STOP};
      state_d   = state_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      wait_d    = wait_q;
      timeout_d = 1'b0;
      cnt_d     = serial && !bit_end ? cnt_q + 1'b1 : '0;
      case (state_q)
         IDLE: state_d = fifo_empty_i ? IDLE : REQ;
         REQ: begin
            state_d = WAIT_DV;
            wait_d  = '0;
         end
         WAIT_DV: begin
            if (fifo_rd_dv_i) begin
               shift_d = fifo_rd_data_i;
               state_d = START;
            end else if (wait_q == WAIT_LAST) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               bit_d   = bit_q + 1'b1;
               state_d = bit_q == 3'd7 ? STOP : DATA;
            end
         end
         STOP: state_d = bit_end ? IDLE : STOP;
         default: state_d = IDLE;
      endcase
      tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[bit_d] : 1'b1;
   end
   assign fifo_rd_en_o = state_q == REQ;
   assign busy_o       = state_q != IDLE;
   assign done_o       = state_q == STOP && bit_end;
   assign timeout_o    = timeout_q;
   assign tx_o         = tx_q;
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the FIFO read port: pops one byte at a time and serialises it as UART 8N1 on a single TX line.
- Sits between the FIFO block and the board TX pin, so a producer can burst bytes into the FIFO while this block drains them at line rate.
- Latency-agnostic on the FIFO side: issues a one-cycle read request and captures data only when the FIFO's data-valid returns.

Parameters:
- CLKS_PER_BIT, 217, clk_i cycles per UART bit period (25 MHz / 115200). Must be >= 2.
- DV_TIMEOUT, 15, max cycles to wait for rd_dv_i after a request before abandoning it. Must be >= 1.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous reset, active high.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_rd_en_o  output  1  one-cycle read request to the FIFO.
- fifo_rd_dv_i  input  1  FIFO read data valid.
- fifo_rd_data_i  input  8  FIFO read data; sampled only when fifo_rd_dv_i=1.
- tx_o  output  1  UART serial output, idle high.
- busy_o  output  1  high whenever the state is not IDLE.
- done_o  output  1  one-cycle pulse at the end of each stop bit.
- timeout_o  output  1  one-cycle pulse when a read request gets no data-valid.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, tx_o=1, fifo_rd_en_o=0, busy_o=0, done_o=0, timeout_o=0, bit counter=0, clock counter=0, shift register=0.
- Reset mid-frame: at the next clock edge tx_o is forced to 1 and the frame is abandoned, with no partial stop bit.
- States: IDLE, REQ, WAIT_DV, START, DATA, STOP.
- IDLE:
  - If fifo_empty_i=0, go to REQ.
  - Otherwise stay in IDLE with tx_o=1.
- REQ:
  - fifo_rd_en_o=1 for exactly this one cycle.
  - Next state is WAIT_DV; the wait counter clears to 0.
- WAIT_DV:
  - fifo_rd_en_o=0.
  - If fifo_rd_dv_i=1: latch fifo_rd_data_i into the shift register and go to START.
  - Otherwise increment the wait counter. When it reaches DV_TIMEOUT, pulse timeout_o for one cycle and return to IDLE.
  - rd_dv_i arriving in the same cycle as the timeout is taken as valid; valid wins over timeout.
- START:
  - tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx_o = shift[bit index]; bytes go out LSB first.
  - Each bit is held CLKS_PER_BIT cycles.
  - After bit 7 (index wraps from 7 to 0), go to STOP.
- STOP:
  - tx_o=1 for CLKS_PER_BIT cycles.
  - On the final cycle of the stop bit, done_o=1 for one cycle and the state returns to IDLE.
- Clock counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and clears on every bit-period boundary and on every state entry.
- Bit index is 3 bits wide.
- Back-to-back bytes: after STOP there is one IDLE cycle, then REQ. This gives a fixed inter-frame gap of 1 IDLE + 1 REQ + WAIT_DV cycles, during which tx_o stays high.
- Frame length, START entry to done_o inclusive: exactly 10*CLKS_PER_BIT cycles.
- Request rules:
  - Exactly one fifo_rd_en_o pulse per frame.
  - fifo_rd_en_o is never asserted when fifo_empty_i=1 was sampled in IDLE, so the FIFO's count can never underflow.
- fifo_empty_i is ignored outside IDLE.
- fifo_rd_dv_i is ignored outside WAIT_DV; a spurious dv never loads the shift register.
- tx_o is registered, so it is glitch-free.
- busy_o is combinational from the state register (state != IDLE).

Test Plan:
1. Reset and idle:
   - Stimulus: hold rst_i=1 for 3 cycles, then release with fifo_empty_i=1 for 50 cycles.
   - Required: tx_o=1, busy_o=0, and fifo_rd_en_o never asserted.
2. Single byte, CLKS_PER_BIT=4:
   - Stimulus: FIFO model with 2-cycle read latency holding 0xA5; fifo_empty_i drops.
   - Required: one rd_en pulse, then tx_o carries start 0, bits 1,0,1,0,0,1,0,1, and stop 1, each bit 4 cycles wide.
   - Required: done_o pulses exactly 40 cycles after START entry.
3. Burst:
   - Stimulus: FIFO holding 0x00, 0xFF, 0x3C.
   - Required: three frames decoded by a bench UART receiver in that order; exactly 3 rd_en pulses; 3 done_o pulses; tx_o high between frames.
4. Timeout, DV_TIMEOUT=4:
   - Stimulus: fifo_empty_i=0 but fifo_rd_dv_i is never asserted.
   - Required: timeout_o pulses 4 cycles after entering WAIT_DV, the state returns to IDLE, and tx_o stays 1 throughout.
   - Stimulus: dv asserted on cycle 4.
   - Required: the byte is sent and timeout_o does not pulse.
5. Reset mid-frame:
   - Stimulus: assert rst_i during DATA bit 3 of 0x55.
   - Required: tx_o=1 on the next edge, busy_o=0, and no done_o.
   - Stimulus: after release with FIFO non-empty.
   - Required: a clean full frame follows.
6. Spurious dv:
   - Stimulus: pulse fifo_rd_dv_i with data 0x99 while in DATA.
   - Required: the frame in progress is unchanged and no extra rd_en pulse is issued.
